// File: rtl/alu_pkg.sv
// Shared opcode, width and FSM-state definitions for the multi-cycle ALU.
package alu_pkg;

    localparam int ALU_CTRL_W = 4;

    typedef enum logic [ALU_CTRL_W-1:0] {
        OP_AND  = 4'd0,
        OP_XOR  = 4'd1,
        OP_SLL  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_MUL  = 4'd5,
        OP_OR   = 4'd6,
        OP_SRA  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLTU = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mc_if.sv
// Request/result handshake bundle for alu_mc; master issues operations, slave is the ALU.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    import alu_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      data1;
    logic [WIDTH-1:0]      data2;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      data;
    logic                  zero;
    logic                  eq;
    logic                  ovf;

    modport master (
        output in_valid, data1, data2, alu_ctrl, out_ready,
        input  in_ready, out_valid, data, zero, eq, ovf
    );

    modport slave (
        input  in_valid, data1, data2, alu_ctrl, out_ready,
        output in_ready, out_valid, data, zero, eq, ovf
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
// product presents the accumulator value that the current iteration will store.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplr_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt_reg;

    assign acc_next = acc_reg + (mplr_reg[0] ? mcand_reg : '0);
    assign busy     = (cnt_reg != '0);
    // done flags the final iteration so the caller can register product at this edge
    assign done     = (cnt_reg == CW'(1));
    assign product  = acc_next;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mcand_reg <= '0;
            mplr_reg  <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else if (start) begin
            mcand_reg <= multiplicand;
            mplr_reg  <= multiplier;
            acc_reg   <= '0;
            cnt_reg   <= CW'(WIDTH);
        end else if (busy) begin
            mcand_reg <= mcand_reg << 1;
            mplr_reg  <= mplr_reg >> 1;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_reg - CW'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/compare ops, iterative MUL,
// valid/ready handshake on both request and result sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WIDTH-1:0]      data1_i,
    input  logic [WIDTH-1:0]      data2_i,
    input  logic [ALU_CTRL_W-1:0] ALUCtrl_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  zero_o,
    output logic                  eq_o,
    output logic                  ovf_o
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_e              state_reg, state_next;
    logic [WIDTH-1:0]        data_reg;
    logic                    zero_reg, eq_reg, ovf_reg, valid_reg, mul_eq_reg;
    logic                    accept, is_mul, mul_start, mul_busy, mul_done, mul_fin;
    logic [WIDTH-1:0]        mul_product, alu_res, sum, diff;
    logic signed [WIDTH-1:0] sra_res;
    logic                    alu_ovf;
    logic [SHW-1:0]          shamt;

    // Reset term keeps in_ready low while the block is held in reset
    assign in_ready_o = rst_n_i && (state_reg == IDLE) && (!valid_reg || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign is_mul     = (ALUCtrl_i == OP_MUL);
    assign mul_start  = accept && is_mul;
    assign mul_fin    = (state_reg == MUL) && mul_done;

    assign shamt   = data2_i[SHW-1:0];
    assign sum     = data1_i + data2_i;
    assign diff    = data1_i - data2_i;
    assign sra_res = $signed(data1_i) >>> shamt;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUCtrl_i)
            OP_AND:  alu_res = data1_i & data2_i;
            OP_XOR:  alu_res = data1_i ^ data2_i;
            OP_OR:   alu_res = data1_i | data2_i;
            OP_SLL:  alu_res = data1_i << shamt;
            OP_SRL:  alu_res = data1_i >> shamt;
            OP_SRA:  alu_res = sra_res;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) && (sum[WIDTH-1] != data1_i[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) && (diff[WIDTH-1] != data1_i[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(data1_i) < $signed(data2_i)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, data1_i < data2_i};
            default: alu_res = '0;
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .start        (mul_start),
        .multiplicand (data1_i),
        .multiplier   (data2_i),
        .busy         (mul_busy),
        .done         (mul_done),
        .product      (mul_product)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // A MUL result lands in HOLD only when the consumer is already stalling
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (mul_start) state_next = MUL;
            MUL: begin
                if (mul_done)       state_next = out_ready_i ? IDLE : HOLD;
                else if (!mul_busy) state_next = IDLE;
            end
            HOLD: if (out_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_reg   <= '0;
            zero_reg   <= 1'b0;
            eq_reg     <= 1'b0;
            ovf_reg    <= 1'b0;
            valid_reg  <= 1'b0;
            mul_eq_reg <= 1'b0;
        end else begin
            if (mul_start) mul_eq_reg <= (data1_i == data2_i);
            if (accept && !is_mul) begin
                data_reg  <= alu_res;
                zero_reg  <= (alu_res == '0);
                eq_reg    <= (data1_i == data2_i);
                ovf_reg   <= alu_ovf;
                valid_reg <= 1'b1;
            end else if (mul_fin) begin
                data_reg  <= mul_product;
                zero_reg  <= (mul_product == '0);
                eq_reg    <= mul_eq_reg;
                ovf_reg   <= 1'b0;
                valid_reg <= 1'b1;
            end else if (out_ready_i) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid_o = valid_reg;
    assign data_o      = data_reg;
    assign zero_o      = zero_reg;
    assign eq_o        = eq_reg;
    assign ovf_o       = ovf_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32 and WIDTH=8.
module tb_alu_mc;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(32)) bus32 ();
    alu_mc_if #(.WIDTH(8))  bus8 ();

    alu_mc #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_valid_i(bus32.in_valid), .in_ready_o(bus32.in_ready),
        .data1_i(bus32.data1), .data2_i(bus32.data2), .ALUCtrl_i(bus32.alu_ctrl),
        .out_valid_o(bus32.out_valid), .out_ready_i(bus32.out_ready),
        .data_o(bus32.data), .zero_o(bus32.zero), .eq_o(bus32.eq), .ovf_o(bus32.ovf)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_valid_i(bus8.in_valid), .in_ready_o(bus8.in_ready),
        .data1_i(bus8.data1), .data2_i(bus8.data2), .ALUCtrl_i(bus8.alu_ctrl),
        .out_valid_o(bus8.out_valid), .out_ready_i(bus8.out_ready),
        .data_o(bus8.data), .zero_o(bus8.zero), .eq_o(bus8.eq), .ovf_o(bus8.ovf)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic op32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus32.alu_ctrl = op;
        bus32.data1    = a;
        bus32.data2    = b;
        bus32.in_valid = 1'b1;
        tick();
        bus32.in_valid = 1'b0;
        $display("txn w32 op=%0d a=0x%08h b=0x%08h -> data=0x%08h v=%0b z=%0b eq=%0b ovf=%0b",
                 op, a, b, bus32.data, bus32.out_valid, bus32.zero, bus32.eq, bus32.ovf);
    endtask

    task automatic op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus8.alu_ctrl = op;
        bus8.data1    = a;
        bus8.data2    = b;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        $display("txn w8 op=%0d a=0x%02h b=0x%02h -> data=0x%02h v=%0b z=%0b eq=%0b ovf=%0b",
                 op, a, b, bus8.data, bus8.out_valid, bus8.zero, bus8.eq, bus8.ovf);
    endtask

    initial begin
        int seen;
        vecs[0]  = '{4'd0,  32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0};
        vecs[1]  = '{4'd1,  32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1'b0};
        vecs[2]  = '{4'd2,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0};
        vecs[3]  = '{4'd6,  32'h12340000, 32'h00005678, 32'h12345678, 1'b0};
        vecs[4]  = '{4'd4,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
        vecs[5]  = '{4'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        vecs[6]  = '{4'd9,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0};
        vecs[7]  = '{4'd10, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[8]  = '{4'd7,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0};
        vecs[9]  = '{4'd8,  32'h80000000, 32'h00000024, 32'h08000000, 1'b0};
        vecs[10] = '{4'd4,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[11] = '{4'd15, 32'h12345678, 32'h00000001, 32'h00000000, 1'b0};

        bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
        bus32.data1 = '0; bus32.data2 = '0; bus32.alu_ctrl = '0;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
        bus8.data1 = '0; bus8.data2 = '0; bus8.alu_ctrl = '0;

        // Reset state
        #1;
        check("rst in_ready", bus32.in_ready, 1'b0);
        check("rst out_valid", bus32.out_valid, 1'b0);
        check("rst data", bus32.data, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("post-rst in_ready", bus32.in_ready, 1'b1);

        // ADD overflow, one-cycle latency
        op32(OP_ADD, 32'h7FFFFFFF, 32'h00000001);
        check("add data", bus32.data, 32'h80000000);
        check("add ovf", bus32.ovf, 1'b1);
        check("add zero", bus32.zero, 1'b0);
        check("add valid", bus32.out_valid, 1'b1);

        // Back-to-back table
        for (int i = 0; i < NV; i++) begin
            op32(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d data", i), bus32.data, vecs[i].res);
            check($sformatf("vec%0d ovf", i), bus32.ovf, vecs[i].ovf);
            check($sformatf("vec%0d zero", i), bus32.zero, vecs[i].res == 32'h0);
            check($sformatf("vec%0d valid", i), bus32.out_valid, 1'b1);
        end
        tick();
        check("valid clears", bus32.out_valid, 1'b0);

        // SUB 5-5 with consumer stalled for 5 cycles
        op32(OP_SUB, 32'd5, 32'd5);
        bus32.out_ready = 1'b0;
        bus32.alu_ctrl = OP_ADD; bus32.data1 = 32'd2; bus32.data2 = 32'd3;
        bus32.in_valid = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d in_ready", k), bus32.in_ready, 1'b0);
            check($sformatf("hold%0d data", k), bus32.data, 32'h0);
            check($sformatf("hold%0d zero", k), bus32.zero, 1'b1);
            check($sformatf("hold%0d eq", k), bus32.eq, 1'b1);
            check($sformatf("hold%0d valid", k), bus32.out_valid, 1'b1);
            tick();
        end
        bus32.out_ready = 1'b1;
        #1;
        check("release in_ready", bus32.in_ready, 1'b1);
        op32(OP_ADD, 32'd2, 32'd3);
        check("no-bubble data", bus32.data, 32'd5);
        check("no-bubble valid", bus32.out_valid, 1'b1);
        check("no-bubble eq", bus32.eq, 1'b0);
        tick();

        // MUL -3 * 7, result exactly 32 edges after accept
        op32(OP_MUL, 32'hFFFFFFFD, 32'd7);
        for (int k = 1; k < 32; k++) begin
            check($sformatf("mul busy e%0d", k), {bus32.out_valid, bus32.in_ready}, 2'b00);
            tick();
        end
        check("mul busy e31 in_ready", bus32.in_ready, 1'b0);
        tick();
        check("mul data", bus32.data, 32'hFFFFFFEB);
        check("mul valid", bus32.out_valid, 1'b1);
        check("mul ovf", bus32.ovf, 1'b0);
        check("mul in_ready after", bus32.in_ready, 1'b1);
        tick();

        // MUL completing into a stalled consumer
        op32(OP_MUL, 32'd3, 32'd4);
        bus32.out_ready = 1'b0;
        repeat (31) tick();
        check("mulhold early valid", bus32.out_valid, 1'b0);
        tick();
        check("mulhold data", bus32.data, 32'd12);
        check("mulhold valid", bus32.out_valid, 1'b1);
        repeat (2) tick();
        check("mulhold stable data", bus32.data, 32'd12);
        check("mulhold in_ready", bus32.in_ready, 1'b0);
        bus32.out_ready = 1'b1;
        tick();
        check("mulhold clear", bus32.out_valid, 1'b0);
        check("mulhold idle ready", bus32.in_ready, 1'b1);

        // Reset in the middle of a MUL
        op32(OP_MUL, 32'd5, 32'd5);
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort valid", bus32.out_valid, 1'b0);
        check("abort in_ready", bus32.in_ready, 1'b0);
        check("abort data", bus32.data, 32'h0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus32.out_valid) seen++;
        end
        check("abort no result", seen, 0);
        op32(OP_AND, 32'h0000F0F0, 32'h00000FF0);
        check("after-abort and", bus32.data, 32'h000000F0);
        tick();

        // WIDTH = 8 regression
        op8(OP_SLT, 8'hFF, 8'h01);
        check("w8 slt", bus8.data, 8'h01);
        op8(OP_SLTU, 8'hFF, 8'h01);
        check("w8 sltu", bus8.data, 8'h00);
        op8(4'd12, 8'h55, 8'h33);
        check("w8 op12 data", bus8.data, 8'h00);
        check("w8 op12 ovf", bus8.ovf, 1'b0);
        check("w8 op12 zero", bus8.zero, 1'b1);
        op8(OP_ADD, 8'h7F, 8'h01);
        check("w8 add ovf", bus8.ovf, 1'b1);
        op8(OP_MUL, 8'h0D, 8'h13);
        repeat (7) tick();
        check("w8 mul early", bus8.out_valid, 1'b0);
        tick();
        check("w8 mul data", bus8.data, 8'hF7);
        check("w8 mul valid", bus8.out_valid, 1'b1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning operand and result width in bits; legal values 8..64, power of two.
REQ-002 The module SHALL have derived constant SHW = clog2(WIDTH), meaning shift-amount width; it is not overridable.
REQ-003 Port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n_i  input  1  reset; asynchronous and active-low.
REQ-005 Port: in_valid_i  input  1  operation request valid.
REQ-006 Port: in_ready_o  output  1  block accepts a request this cycle.
REQ-007 Port: data1_i  input  WIDTH  operand A, two's complement.
REQ-008 Port: data2_i  input  WIDTH  operand B, two's complement.
REQ-009 Port: ALUCtrl_i  input  4  opcode.
REQ-010 Port: out_valid_o  output  1  result valid.
REQ-011 Port: out_ready_i  input  1  consumer accepts the result.
REQ-012 Port: data_o  output  WIDTH  result.
REQ-013 Port: zero_o  output  1  data_o equals 0.
REQ-014 Port: eq_o  output  1  accepted operands were equal.
REQ-015 Port: ovf_o  output  1  signed overflow of ADD/SUB; 0 for all other ops.

Function
REQ-016 Opcodes SHALL be: 0 AND, 1 XOR, 2 SLL, 3 ADD, 4 SUB, 5 MUL, 6 OR, 7 SRA, 8 SRL, 9 SLT, 10 SLTU; opcodes 11-15 SHALL produce data_o = 0, ovf_o = 0.
REQ-017 Shifts SHALL use only data2_i[SHW-1:0] as the shift amount.
REQ-018 MUL SHALL return the low WIDTH bits of the product.
REQ-019 SLT and SLTU SHALL return 1 or 0 zero-extended to WIDTH, with SLT signed and SLTU unsigned.
REQ-020 A request SHALL be accepted at a rising edge where in_valid_i and in_ready_o are both 1; operands and opcode are captured at that edge.
REQ-021 in_ready_o SHALL equal (state == IDLE) and (out_valid_o == 0 or out_ready_i == 1); it has no combinational path from in_valid_i.
REQ-022 The FSM SHALL have states IDLE, MUL and HOLD.
REQ-023 IDLE, non-MUL request accepted: the result SHALL be registered at the accept edge, out_valid_o = 1 from that edge, and the FSM SHALL stay in IDLE (1-cycle latency, back-to-back throughput).
REQ-024 IDLE, MUL request accepted: the FSM SHALL go to MUL and load a WIDTH-iteration counter.
REQ-025 In state MUL the block SHALL perform one shift-add iteration per cycle; after WIDTH iterations the result SHALL be registered, out_valid_o set and the FSM SHALL return to IDLE; the result is therefore visible WIDTH edges after acceptance.
REQ-026 Result valid with out_ready_i = 0: data_o, zero_o, eq_o, ovf_o and out_valid_o SHALL hold stable (state HOLD if entered from MUL completion, or IDLE with in_ready_o = 0).
REQ-027 out_valid_o SHALL clear at an edge with out_ready_i = 1 unless a new result is registered at the same edge.
REQ-028 When out_ready_i = 1 and a new request is accepted at the same edge, the new result SHALL replace the old one with no bubble.
REQ-029 ovf_o SHALL be 1 when operands have equal sign (ADD) or different sign (SUB) and the result sign differs from data1_i.
REQ-030 zero_o and eq_o SHALL be registered together with data_o.

Reset
REQ-031 Asserting rst_n_i = 0 SHALL immediately force state IDLE, out_valid_o = 0, data_o = 0, zero_o = 0, eq_o = 0, ovf_o = 0 and counter = 0.
REQ-032 Reset during MUL or HOLD SHALL abort the operation; the result is discarded and never presented.
REQ-033 in_ready_o SHALL be 0 while rst_n_i = 0 and SHALL be 1 at the first edge after deassertion.

Structure
REQ-034 Package alu_pkg SHALL hold the 4-bit opcode enum, ALU_CTRL_W = 4 and the FSM state typedef.
REQ-035 The iterative multiplier SHALL be sub-module alu_mul_iter with ports start, busy and done, parametrised by WIDTH.
REQ-036 All other ops SHALL be combinational logic inside alu_mc feeding the result register.

Verification
REQ-037 WIDTH = 32: ADD 0x7FFFFFFF + 1 -> next cycle data_o = 0x80000000, ovf_o = 1, zero_o = 0.
REQ-038 MUL -3 * 7 -> data_o = 0xFFFFFFEB exactly 32 edges after accept; in_ready_o = 0 throughout.
REQ-039 SRA 0x80000000 by data2 = 0x24 (effective 4) -> 0xF8000000; SRL of the same operands -> 0x08000000.
REQ-040 out_ready_i held 0 for 5 cycles after a SUB 5-5 result: data_o = 0, zero_o = 1 and eq_o = 1 stay stable, in_ready_o = 0; the first edge with out_ready_i = 1 accepts the next request with no bubble.
REQ-041 rst_n_i pulsed low mid-MUL (iteration 10): out_valid_o = 0 immediately, no result ever appears, and a following AND 0xF0F0 & 0x0FF0 returns 0x00F0.
REQ-042 WIDTH = 8 regression: SLT -1 < 1 -> 1; SLTU 0xFF < 0x01 -> 0; opcode 12 -> 0.
